// File: rtl/lockstep_pkg.sv
// rtl/lockstep_pkg.sv - shared state type and default widths for lockstep_checker
package lockstep_pkg;

   localparam int VEC_W_DEF = 12;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_WARMUP,
      ST_ARMED,
      ST_FAILED,
      ST_HALT
   } lockstep_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/lockstep_checker.sv
// rtl/lockstep_checker.sv - compares reference/DUT responses after a warm-up window
// Optional LOCKSTEP_CHECKER_STOP_ON_FAIL_EN: halt and raise stop on the first mismatch.
module lockstep_checker
   import lockstep_pkg::*;
#(
   parameter int VEC_W  = VEC_W_DEF,
   parameter int WARMUP = 2,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [VEC_W-1:0] in_vec,
   input  logic             o_ref,
   input  logic             o_dut,
   output logic             armed,
   output logic             error,
   output logic             stop,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [VEC_W-1:0] fail_vec,
   output logic             fail_ref,
   output logic             fail_dut,
   output logic [CNT_W-1:0] fail_idx
);

   localparam lockstep_state_t RESET_ST = (WARMUP == 0) ? ST_ARMED : ST_WARMUP;
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

   lockstep_state_t  state_q, state_d;
   logic [CNT_W-1:0] warm_cnt;
   logic             accept_warm, comparing, mism, capture;
   logic             armed_q, armed_d, error_q, error_d;
   logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
   logic             fail_ref_q, fail_ref_d, fail_dut_q, fail_dut_d;
   logic [CNT_W-1:0] fail_idx_q, fail_idx_d;

   // clear beats a coincident sample, so it gates every counter increment
   assign accept_warm = in_valid && !clear && (state_q == ST_WARMUP);
   assign comparing   = in_valid && !clear && ((state_q == ST_ARMED) || (state_q == ST_FAILED));
   assign mism        = comparing && (o_ref != o_dut);

   sat_counter #(.W(CNT_W)) u_warm_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(accept_warm), .q(warm_cnt)
   );
   sat_counter #(.W(CNT_W)) u_sample_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(comparing), .q(sample_cnt)
   );
   sat_counter #(.W(CNT_W)) u_mismatch_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(mism), .q(mismatch_cnt)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      if (clear) begin
         state_d = RESET_ST;
      end else begin
         case (state_q)
            ST_WARMUP: if (accept_warm && (warm_cnt == WARM_LAST)) state_d = ST_ARMED;
            ST_ARMED: begin
               if (mism) begin
                  capture = 1'b1;
`ifdef LOCKSTEP_CHECKER_STOP_ON_FAIL_EN
                  state_d = ST_HALT;
`else
                  state_d = ST_FAILED;
`endif
               end
            end
            ST_FAILED: state_d = ST_FAILED;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = RESET_ST;
         endcase
      end
   end

   always_comb begin
      armed_d    = (state_d != ST_WARMUP);
      error_d    = clear ? 1'b0 : (error_q || mism);
      fail_vec_d = fail_vec_q;
      fail_ref_d = fail_ref_q;
      fail_dut_d = fail_dut_q;
      fail_idx_d = fail_idx_q;
      if (clear) begin
         fail_vec_d = '0;
         fail_ref_d = 1'b0;
         fail_dut_d = 1'b0;
         fail_idx_d = '0;
      end else if (capture) begin
         fail_vec_d = in_vec;
         fail_ref_d = o_ref;
         fail_dut_d = o_dut;
         fail_idx_d = sample_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_ST;
         armed_q    <= (WARMUP == 0);
         error_q    <= 1'b0;
         fail_vec_q <= '0;
         fail_ref_q <= 1'b0;
         fail_dut_q <= 1'b0;
         fail_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         error_q    <= error_d;
         fail_vec_q <= fail_vec_d;
         fail_ref_q <= fail_ref_d;
         fail_dut_q <= fail_dut_d;
         fail_idx_q <= fail_idx_d;
      end
   end

`ifdef LOCKSTEP_CHECKER_STOP_ON_FAIL_EN
   logic stop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_q <= 1'b0;
      end else begin
         stop_q <= (state_d == ST_HALT);
      end
   end

   assign stop = stop_q;
`else
   assign stop = 1'b0;
`endif

   assign armed    = armed_q;
   assign error    = error_q;
   assign fail_vec = fail_vec_q;
   assign fail_ref = fail_ref_q;
   assign fail_dut = fail_dut_q;
   assign fail_idx = fail_idx_q;

endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Synthesizable lockstep comparator: the receiving end of the block-equivalence flow. It consumes the stimulus vector plus the two single-bit responses (reference model, DUT) each valid cycle. It ignores a warm-up window, flags and captures the first mismatch, and counts every mismatch. It sits after the paired instances in FPGA-hosted equivalence runs, where `$display`/`$stop` are unavailable.

## Interface
- `VEC_W`, 12, stimulus vector width (four 3-bit operands a,b,c,d concatenated {a,b,c,d}).
- `WARMUP`, 2, number of leading valid samples discarded after reset/clear (0 allowed).
- `CNT_W`, 16, width of sample and mismatch counters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous restart: zero counters and captures, re-enter warm-up.
- `in_valid`  in  1  sample qualifier.
- `in_vec`  in  VEC_W  stimulus applied to both instances.
- `o_ref`  in  1  reference-model response.
- `o_dut`  in  1  DUT response.
- `armed`  out  1  warm-up complete, comparisons active.
- `error`  out  1  sticky: at least one mismatch since reset/clear.
- `stop`  out  1  halt request to the stimulus source (see Configuration).
- `sample_cnt`  out  CNT_W  compared (post-warm-up) samples, saturating.
- `mismatch_cnt`  out  CNT_W  mismatching samples, saturating.
- `fail_vec`  out  VEC_W  in_vec of first mismatch.
- `fail_ref`, `fail_dut`  out  1 each  responses at first mismatch.
- `fail_idx`  out  CNT_W  0-based post-warm-up index of first mismatch.

## Operation
- FSM states: WARMUP, ARMED, FAILED, HALT.
- WARMUP: each `in_valid` increments the internal warm-up counter. The sample that makes the count reach `WARMUP` moves the FSM to ARMED without being compared. With `WARMUP`=0, reset goes directly to ARMED.
- ARMED: each `in_valid` is compared as `o_ref != o_dut` and `sample_cnt` increments.
- On mismatch: `mismatch_cnt` increments and `error` is set. `fail_*` are loaded with the current sample and `fail_idx` = current `sample_cnt` value (pre-increment). FSM goes to FAILED, or to HALT when the macro is enabled.
- FAILED: comparisons and counting continue. `fail_*` are frozen, and only the first mismatch is captured.
- HALT: `in_valid` is ignored and all counters freeze. The FSM leaves HALT only by `clear` or reset.
- Counters saturate at all-ones and never wrap. Comparison still works after saturation.
- `clear` and `in_valid` in the same cycle: `clear` wins and the sample is discarded.
- Reset values: state WARMUP (ARMED if `WARMUP`=0). `armed`, `error`, and `stop` are 0. All counters and `fail_*` are 0.

## Timing
- All outputs are registered. A sample presented at edge N is reflected in outputs after edge N.
- `error`, `mismatch_cnt`, and `fail_*` update at the same edge.
- `armed` rises at the edge that accepts the last warm-up sample.
- Asynchronous reset mid-run clears everything immediately. The first valid sample after release counts as warm-up sample 0.
- `clear` takes effect at the next edge. Outputs return to reset values one cycle later.

## Configuration
- `LOCKSTEP_CHECKER_STOP_ON_FAIL_EN` defined:
  - The first mismatch enters HALT and `stop` is asserted from that edge until `clear` or reset.
  - `mismatch_cnt` ends at 1.
- Undefined:
  - HALT is unreachable and `stop` is tied 0.
  - FAILED keeps counting all mismatches.

## Structure
- Package `lockstep_pkg`: state enum `lockstep_state_t` (WARMUP, ARMED, FAILED, HALT), default widths `VEC_W_DEF`=12 and `CNT_W_DEF`=16.
- Sub-module `sat_counter` (parameter `W`; inputs `clr`, `inc`; output `q`, saturating). Instantiated for the warm-up, sample and mismatch counters.

## Test plan
- Reset, `WARMUP`=2, three valid samples with `o_ref`=`o_dut`=1:
  - `armed` rises after the 2nd sample.
  - `sample_cnt`=1, `error`=0.
- Armed; sample 5 post-warm-up has in_vec=12'hA53, `o_ref`=1, `o_dut`=0:
  - Next edge: `error`=1, `fail_vec`=12'hA53, `fail_ref`=1, `fail_dut`=0, `fail_idx`=5, `mismatch_cnt`=1.
- Macro undefined; three further mismatches:
  - `mismatch_cnt`=4.
  - `fail_*` unchanged, `stop`=0.
- Macro defined; one mismatch then 10 valid samples:
  - `stop`=1, `mismatch_cnt`=1, `sample_cnt` frozen.
  - `clear` returns all outputs to 0.
- `CNT_W`=4; 20 mismatching samples:
  - `mismatch_cnt` holds 4'hF.
  - `sample_cnt`=4'hF.
- Assert `rst_n`=0 mid-run between clock edges:
  - Outputs zero immediately.
  - After release, the first two valid samples are not compared even if mismatching.
